// File: rtl/arb4_grant_ctrl.sv
// Four-requester arbiter for one shared resource. It issues a registered one-hot grant
// and its encoded index, supports fixed or round-robin priority, and can revoke a grant
// with a hold timer.
module arb4_grant_ctrl #(
    parameter bit          RR_MODE  = 1'b1,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic [1:0]       last_id, last_id_nx;
    logic [3:0]       gnt_nx;
    logic [1:0]       gnt_id_nx;
    logic             gnt_valid_nx;
    logic             timeout_nx;

    logic [1:0]       win_id;
    logic [1:0]       scan_id;
    logic             found;
    logic             timer_hit;
    logic             owner_req;
    logic             release_c;

    // Winner pick: the highest index in fixed mode; otherwise scan upward from last_id+1 and wrap.
    always_comb begin
        win_id  = 2'd0;
        scan_id = 2'd0;
        found   = 1'b0;
        if (RR_MODE) begin
            for (int i = 1; i <= 4; i++) begin
                scan_id = last_id + 2'(i);
                if (!found && req[scan_id]) begin
                    win_id = scan_id;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    win_id = 2'(i);
                end
            end
        end
    end

    assign timer_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign owner_req = req[gnt_id];
    assign release_c = done || !owner_req || timer_hit;

    always_comb begin
        state_nx     = state;
        gnt_nx       = gnt;
        gnt_id_nx    = gnt_id;
        gnt_valid_nx = gnt_valid;
        timeout_nx   = 1'b0;
        hold_cnt_nx  = hold_cnt;
        last_id_nx   = last_id;

        case (state)
            IDLE: begin
                gnt_nx       = 4'b0000;
                gnt_valid_nx = 1'b0;
                hold_cnt_nx  = '0;
                if (req != 4'b0000) begin
                    state_nx     = GRANT;
                    gnt_nx       = 4'b0001 << win_id;
                    gnt_id_nx    = win_id;
                    gnt_valid_nx = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_nx     = IDLE;
                    gnt_nx       = 4'b0000;
                    gnt_valid_nx = 1'b0;
                    last_id_nx   = gnt_id;
                    hold_cnt_nx  = '0;
                    // A timeout is flagged only when the hold timer is the sole release cause.
                    timeout_nx   = timer_hit && !done && owner_req;
                end else if (hold_cnt != CNT_MAX) begin
                    hold_cnt_nx = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last_id   <= 2'd3;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gnt_id    <= gnt_id_nx;
            gnt_valid <= gnt_valid_nx;
            timeout   <= timeout_nx;
            hold_cnt  <= hold_cnt_nx;
            last_id   <= last_id_nx;
        end
    end

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// Bench for arb4_grant_ctrl. Four configurations share the stimulus: fixed/16,
// round-robin/16, fixed/hold-1, and round-robin/unlimited.
module tb_arb4_grant_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt_a       [4];
    logic [1:0] gnt_id_a    [4];
    logic       gnt_valid_a [4];
    logic       timeout_a   [4];

    int checks = 0;
    int errors = 0;

    int rr_p [4] = '{0, 1, 0, 1};
    int mh_p [4] = '{16, 16, 1, 0};

    // Instance 0: fixed, 1: round-robin, 2: fixed MAX_HOLD=1, 3: round-robin unlimited
    localparam int FX = 0, RR = 1, H1 = 2, H0 = 3;

    arb4_grant_ctrl #(.RR_MODE(1'b0), .MAX_HOLD(16), .CNT_W(5)) dut_fx (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a[0]), .gnt_id(gnt_id_a[0]), .gnt_valid(gnt_valid_a[0]), .timeout(timeout_a[0]));
    arb4_grant_ctrl #(.RR_MODE(1'b1), .MAX_HOLD(16), .CNT_W(5)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a[1]), .gnt_id(gnt_id_a[1]), .gnt_valid(gnt_valid_a[1]), .timeout(timeout_a[1]));
    arb4_grant_ctrl #(.RR_MODE(1'b0), .MAX_HOLD(1), .CNT_W(2)) dut_h1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a[2]), .gnt_id(gnt_id_a[2]), .gnt_valid(gnt_valid_a[2]), .timeout(timeout_a[2]));
    arb4_grant_ctrl #(.RR_MODE(1'b1), .MAX_HOLD(0), .CNT_W(2)) dut_h0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a[3]), .gnt_id(gnt_id_a[3]), .gnt_valid(gnt_valid_a[3]), .timeout(timeout_a[3]));

    always #5 clk = ~clk;

    // Reference model: owner, cycles held so far, and the previous owner for each configuration
    bit m_busy [4];
    int m_id   [4];
    int m_last [4];
    int m_age  [4];
    bit m_to   [4];
    bit started = 1'b0;

    function automatic int pick(input int k, input logic [3:0] r);
        int w = 0;
        if (rr_p[k] != 0) begin
            for (int d = 4; d >= 1; d--) begin
                if (r[(m_last[k] + d) % 4]) w = (m_last[k] + d) % 4;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r[i]) w = i;
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0; m_id[k] = 0; m_last[k] = 3; m_age[k] = 0; m_to[k] = 1'b0;
            end else if (!m_busy[k]) begin
                m_to[k] = 1'b0;
                if (req != 4'b0000) begin
                    m_id[k] = pick(k, req); m_busy[k] = 1'b1; m_age[k] = 1;
                end
            end else begin
                automatic bit timer = (mh_p[k] != 0) && (m_age[k] == mh_p[k]);
                automatic bit rel   = done || !req[m_id[k]] || timer;
                if (rel) begin
                    m_busy[k] = 1'b0; m_last[k] = m_id[k]; m_age[k] = 0;
                    m_to[k]   = timer && !done && req[m_id[k]];
                end else begin
                    m_age[k] = m_age[k] + 1; m_to[k] = 1'b0;
                end
            end
        end
        started = 1'b1;
    end

    task automatic chk(input string name, input int k, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%b expected=%b at %0t", name, k, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 4; k++) begin
                automatic logic [3:0] eg = m_busy[k] ? 4'(1 << m_id[k]) : 4'b0000;
                chk("gnt", k, gnt_a[k], eg);
                chk("gnt_id", k, 4'(gnt_id_a[k]), 4'(m_id[k]));
                chk("gnt_valid", k, 4'(gnt_valid_a[k]), 4'(m_busy[k]));
                chk("timeout", k, 4'(timeout_a[k]), 4'(m_to[k]));
            end
        end
    end

    task automatic cyc(input logic [3:0] r, input logic d, input int n);
        req  = r;
        done = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            chk("lit_rst_gnt", k, gnt_a[k], 4'b0000);
            chk("lit_rst_id", k, 4'(gnt_id_a[k]), 4'd0);
        end

        // Fixed priority: requester 2 keeps winning over requester 0
        cyc(4'b0101, 1'b0, 1);
        chk("lit_fx_first", FX, gnt_a[FX], 4'b0100);
        chk("lit_fx_first_id", FX, 4'(gnt_id_a[FX]), 4'd2);
        for (int n = 0; n < 2; n++) begin
            cyc(4'b0101, 1'b0, 2);
            cyc(4'b0101, 1'b1, 1);
            chk("lit_fx_rel", FX, gnt_a[FX], 4'b0000);
            cyc(4'b0101, 1'b0, 1);
            chk("lit_fx_regnt", FX, gnt_a[FX], 4'b0100);
        end
        cyc(4'b0001, 1'b0, 1);
        chk("lit_fx_drop", FX, gnt_a[FX], 4'b0000);
        cyc(4'b0001, 1'b0, 1);
        chk("lit_fx_low", FX, gnt_a[FX], 4'b0001);
        cyc(4'b0001, 1'b1, 1);
        cyc(4'b0000, 1'b0, 2);

        // Round-robin rotation with done on every first grant cycle
        do_reset();
        for (int n = 0; n < 5; n++) begin
            cyc(4'b1111, 1'b0, 1);
            chk("lit_rr_rot", RR, gnt_a[RR], rr_seq[n]);
            cyc(4'b1111, 1'b1, 1);
            chk("lit_rr_gap", RR, gnt_a[RR], 4'b0000);
        end
        cyc(4'b0000, 1'b0, 2);

        // Hold timer expiry, including MAX_HOLD=1 and unlimited hold
        do_reset();
        cyc(4'b0010, 1'b0, 1);
        chk("lit_h1_gnt", H1, gnt_a[H1], 4'b0010);
        cyc(4'b0010, 1'b0, 1);
        chk("lit_h1_to", H1, 4'(timeout_a[H1]), 4'd1);
        chk("lit_h1_clr", H1, gnt_a[H1], 4'b0000);
        cyc(4'b0010, 1'b0, 14);
        chk("lit_fx_hold16", FX, gnt_a[FX], 4'b0010);
        cyc(4'b0010, 1'b0, 1);
        chk("lit_fx_to_gnt", FX, gnt_a[FX], 4'b0000);
        chk("lit_fx_to", FX, 4'(timeout_a[FX]), 4'd1);
        chk("lit_h0_hold", H0, gnt_a[H0], 4'b0010);
        cyc(4'b0010, 1'b0, 1);
        chk("lit_fx_regnt2", FX, gnt_a[FX], 4'b0010);
        chk("lit_fx_to_off", FX, 4'(timeout_a[FX]), 4'd0);

        // done coinciding with the last hold cycle is a normal release
        cyc(4'b0010, 1'b0, 15);
        cyc(4'b0010, 1'b1, 1);
        chk("lit_done15_gnt", FX, gnt_a[FX], 4'b0000);
        chk("lit_done15_to", FX, 4'(timeout_a[FX]), 4'd0);
        chk("lit_h0_long", H0, gnt_a[H0], 4'b0000);
        cyc(4'b0010, 1'b0, 4);
        cyc(4'b0000, 1'b0, 1);
        chk("lit_drop_gnt", FX, gnt_a[FX], 4'b0000);
        chk("lit_drop_to", FX, 4'(timeout_a[FX]), 4'd0);
        cyc(4'b0000, 1'b0, 1);

        // Round-robin wrap 3 -> 0 and then 0 -> 3
        do_reset();
        cyc(4'b1000, 1'b0, 1);
        chk("lit_wrap_pre", RR, gnt_a[RR], 4'b1000);
        cyc(4'b1000, 1'b1, 1);
        cyc(4'b1001, 1'b0, 1);
        chk("lit_wrap_0", RR, 4'(gnt_id_a[RR]), 4'd0);
        cyc(4'b1001, 1'b1, 1);
        cyc(4'b1001, 1'b0, 1);
        chk("lit_wrap_3", RR, 4'(gnt_id_a[RR]), 4'd3);

        // Reset during a grant, with done high at the same time
        rst = 1'b1; req = 4'b1111; done = 1'b1;
        @(negedge clk);
        chk("lit_mid_rst_gnt", RR, gnt_a[RR], 4'b0000);
        chk("lit_mid_rst_id", RR, 4'(gnt_id_a[RR]), 4'd0);
        chk("lit_mid_rst_vld", RR, 4'(gnt_valid_a[RR]), 4'd0);
        rst = 1'b0;
        cyc(4'b1111, 1'b0, 1);
        chk("lit_post_rst", RR, gnt_a[RR], 4'b0001);
        cyc(4'b0000, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
